dmem_responder: RTL

- Data-memory responder serving the load/store traffic issued by the core datapath.
- Accepts one request at a time (address, store data, RISC-V funct3 size code). Applies a configurable number of wait states, then commits the store or returns the extended load data with a one-cycle response pulse.
- Sits between the core's memory port and the on-chip data RAM. Multi-cycle and stall-capable core variants use it as their data memory.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, funct3 size codes and byte-lane helper for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Halfwords always snap to the naturally aligned lane pair; unknown sizes touch the whole word.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] mask;
    case (size)
      SZ_B, SZ_BU: mask = 4'b0001 << lo;
      SZ_H, SZ_HU: mask = lo[1] ? 4'b1100 : 4'b0011;
      default:     mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 data RAM, byte-enabled synchronous write, combinational read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with WAIT_CYCLES wait states and load extension.
// Define DMEM_ERR_CHECK_EN for alignment/range/size checking; otherwise rsp_err stays 0 and accesses wrap.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state_r, state_next_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic        accept_s, commit_s;
  logic        we_r;
  logic [31:0] addr_r, wdata_r;
  logic [2:0]  size_r;
  logic        req_ready_r, rsp_valid_r, rsp_err_r;
  logic [31:0] rsp_rdata_r;
  logic        acc_we_s;
  logic [31:0] acc_addr_s, acc_wdata_s;
  logic [2:0]  acc_size_s;
  logic        err_s, mem_we_s;
  logic [3:0]  be_s;
  logic [31:0] rword_s;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] size,
                                              input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = {{24{b[7]}}, b};
      SZ_BU:   r = {24'h000000, b};
      SZ_H:    r = {{16{h[15]}}, h};
      SZ_HU:   r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replicate narrow store data across lanes so the byte enables pick the right copy.
  function automatic logic [31:0] store_align(input logic [31:0] wdata, input logic [2:0] size);
    logic [31:0] r;
    case (size[1:0])
      2'b00:   r = {4{wdata[7:0]}};
      2'b01:   r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  // With zero wait states the access commits on the acceptance edge, straight from the request port.
  always_comb begin
    acc_we_s    = we_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    acc_size_s  = size_r;
    if (state_r == IDLE) begin
      acc_we_s    = req_we;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
      acc_size_s  = req_size;
    end else begin
      acc_we_s    = we_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_size_s  = size_r;
    end
  end

`ifdef DMEM_ERR_CHECK_EN
  logic range_err_s;
  assign range_err_s = ({2'b00, acc_addr_s[31:2]} >= 32'(DEPTH_WORDS));

  // Reject misaligned, out-of-range, illegal-size and unsigned-store requests.
  always_comb begin
    err_s = 1'b0;
    case (acc_size_s)
      SZ_B:    err_s = range_err_s;
      SZ_BU:   err_s = range_err_s | acc_we_s;
      SZ_H:    err_s = range_err_s | acc_addr_s[0];
      SZ_HU:   err_s = range_err_s | acc_addr_s[0] | acc_we_s;
      SZ_W:    err_s = range_err_s | (acc_addr_s[1:0] != 2'b00);
      default: err_s = 1'b1;
    endcase
  end
`else
  logic unused_addr_s;
  assign unused_addr_s = ^acc_addr_s[31:AW+2];
  assign err_s         = 1'b0;
`endif

  assign be_s     = lane_mask(acc_size_s, acc_addr_s[1:0]);
  assign mem_we_s = commit_s & acc_we_s & ~err_s;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (mem_we_s),
    .be    (be_s),
    .addr  (acc_addr_s[AW+1:2]),
    .wdata (store_align(acc_wdata_s, acc_size_s)),
    .rdata (rword_s)
  );

  // Next-state, wait counter and commit strobe.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit_s     = 1'b1;
            state_next_s = RESP;
          end else begin
            cnt_next_s   = 4'(WAIT_CYCLES - 1);
            state_next_s = WAIT;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          commit_s     = 1'b1;
          state_next_s = RESP;
        end else begin
          cnt_next_s   = cnt_r - 4'd1;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      req_ready_r <= (state_next_s == IDLE);
      rsp_valid_r <= (state_next_s == RESP);
    end
  end

  // Request capture and response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r        <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      size_r      <= 3'b000;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        we_r    <= req_we;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        size_r  <= req_size;
      end
      if (commit_s) begin
        rsp_err_r   <= err_s;
        rsp_rdata_r <= (err_s | acc_we_s) ? 32'h0000_0000
                                          : load_extend(rword_s, acc_size_s, acc_addr_s[1:0]);
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule
